dpu_sequencer: RTL
==================

# dpu_sequencer

Run-time controller for the DPU datapath. It holds a table of per-state mode/immediate slots and a sequencing program of per-state dwell delays, last-state index and iteration count. On `activate` it steps the datapath through its states and drives mode, immediate and accumulator-clear. It sits between the resource instruction decoder (which issues slot and program writes) and the DPU arithmetic core.

## Interface
- `NUM_STATES`, 4: number of sequencer states and slots; power of two.
- `DELAY_WIDTH`, 3: width of each per-state dwell delay.
- `MODE_WIDTH`, 6: DPU mode code width.
- `IMM_WIDTH`, 8: immediate width.
- `ITER_WIDTH`, 6: iteration-count width.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `slot_we` in 1: write the slot table.
- `slot_idx` in $clog2(NUM_STATES): slot to write.
- `slot_mode` in MODE_WIDTH: mode value for the slot.
- `slot_imm` in IMM_WIDTH: immediate value for the slot.
- `prog_we` in 1: write the program registers.
- `prog_delays` in (NUM_STATES-1)*DELAY_WIDTH: delay of state s at bits [DELAY_WIDTH*(s+1)-1 : DELAY_WIDTH*s].
- `prog_last` in $clog2(NUM_STATES): index of the final state of one iteration.
- `prog_iter` in ITER_WIDTH: iterations minus one.
- `activate` in 1: start a run.
- `busy` out 1: a run is in progress.
- `done` out 1: one-cycle pulse when a run ends.
- `state` out $clog2(NUM_STATES): current state index.
- `mode` out MODE_WIDTH: current mode to the datapath.
- `immediate` out IMM_WIDTH: current immediate to the datapath.
- `acc_clear` out 1: accumulator clear strobe.

## Operation
- Control FSM states:
  - IDLE: waits for a start. `busy`=0, `state`=0, `mode`=0, `immediate`=0.
  - RUN: steps through the program.
- IDLE→RUN: `activate`=1 and `prog_we`=0. On entry: `state`=0, dwell counter loaded with delay[0] (or 0 if `prog_last`=0), iteration counter loaded with `prog_iter`.
- Dwell in RUN:
  - State s < `prog_last` lasts delay[s]+1 cycles; the counter decrements to 0, then the FSM advances to s+1 and loads delay[s+1].
  - State `prog_last` always lasts exactly 1 cycle. Its delay field is ignored.
- End of the `prog_last` cycle:
  - Iteration counter ≠ 0: decrement it and wrap to state 0.
  - Iteration counter = 0: go to IDLE and pulse `done`.
- Cycles per iteration: Σ_{s<last}(delay[s]+1) + 1. Total run length: that value × (`prog_iter`+1).
- `mode`/`immediate`: read combinationally from slot[`state`] while `busy`; forced to 0 in IDLE.
- Slot writes:
  - Accepted at any time; visible from the next cycle.
  - A write to the slot currently being read shows the old value in the write cycle.
- Program writes: accepted only in IDLE. While `busy` they are dropped and the running program is unaffected.
- Simultaneous events:
  - `activate` while `busy`: ignored.
  - `activate` together with `prog_we` in IDLE: the write commits and `activate` is ignored.
- Reset: slot table, program registers, counters and all outputs go to 0. FSM goes to IDLE. Reset mid-run aborts the run with no `done` pulse.

## Timing
- `activate` sampled at edge T. From T+1: `busy`=1, `state`=0, `acc_clear`=1 for that single cycle.
- `done` is asserted in the first IDLE cycle after the run; `busy` is 0 in that same cycle.
- A new `activate` is accepted in the `done` cycle; the next run starts the cycle after.
- No combinational path from `activate` to any output.

## Configuration
- `DPU_SEQUENCER_ACC_CLEAR_PER_ITER_EN`
  - Defined: `acc_clear` pulses on the first cycle of every iteration (each wrap to state 0 and the run start).
  - Undefined: `acc_clear` pulses only on the first cycle of the run.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, RUN);
  - a packed slot struct {mode, imm};
  - a packed program struct {delays, last, iter};
  - default width constants.
- Sub-module `dpu_seq_slot_table`: NUM_STATES-entry register file with one synchronous write port and one combinational read port indexed by `state`. The top holds the FSM and counters.

## Test plan
- Reset, then `activate` with an all-zero program → one run of 1 cycle: `busy` at T+1 only, `done` at T+2, `acc_clear` at T+1.
- Program delays {2,0,1}, last=3, iter=0; slots mode {1,7,10,1} → `state` reads 0,0,0,1,2,2,3 over T+1..T+7; `mode` reads 1,1,1,7,10,10,1; `done` at T+8.
- Same program with iter=2 → 21 busy cycles, `done` at T+22. `acc_clear` at T+1, T+8, T+15 with the macro defined; only at T+1 without it.
- `prog_we` with last=1 during a run → the current run is unchanged. `activate` together with `prog_we` in IDLE → no start.
- Slot 2 rewritten to mode 7 while `state`=2 → old mode in the write cycle, 7 from the next cycle.
- `rst_n`=0 mid-run → next cycle `busy`=0, `mode`=0, `state`=0, no `done`; a subsequent `activate` runs with the cleared program.

Source files
------------

// File: rtl/dpu_sequencer_pkg.sv
// Shared types and default widths for the DPU run-time sequencer.
// Covers the control FSM states plus the slot and program bundles.
package dpu_sequencer_pkg;

    localparam int DPU_NUM_STATES = 4;
    localparam int DPU_DELAY_W    = 3;
    localparam int DPU_MODE_W     = 6;
    localparam int DPU_IMM_W      = 8;
    localparam int DPU_ITER_W     = 6;
    localparam int DPU_IDX_W      = $clog2(DPU_NUM_STATES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } seq_state_e;

    typedef struct packed {
        logic [DPU_MODE_W-1:0] mode;
        logic [DPU_IMM_W-1:0]  imm;
    } slot_t;

    typedef struct packed {
        logic [(DPU_NUM_STATES-1)*DPU_DELAY_W-1:0] delays;
        logic [DPU_IDX_W-1:0]                      last;
        logic [DPU_ITER_W-1:0]                     iter;
    } prog_t;

endpackage

// File: rtl/dpu_seq_slot_table.sv
// Per-state mode/immediate register file for the DPU sequencer.
// One synchronous write port, one combinational read port.
module dpu_seq_slot_table
    import dpu_sequencer_pkg::*;
#(
    parameter int NUM_STATES = DPU_NUM_STATES,
    parameter int MODE_WIDTH = DPU_MODE_W,
    parameter int IMM_WIDTH  = DPU_IMM_W,
    localparam int IW        = $clog2(NUM_STATES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [IW-1:0]         wr_idx_i,
    input  logic [MODE_WIDTH-1:0] wr_mode_i,
    input  logic [IMM_WIDTH-1:0]  wr_imm_i,
    input  logic [IW-1:0]         rd_idx_i,
    output logic [MODE_WIDTH-1:0] rd_mode_o,
    output logic [IMM_WIDTH-1:0]  rd_imm_o
);

    logic [MODE_WIDTH-1:0] mode_q [NUM_STATES];
    logic [IMM_WIDTH-1:0]  imm_q  [NUM_STATES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                mode_q[i] <= '0;
                imm_q[i]  <= '0;
            end
        end else if (we_i) begin
            mode_q[wr_idx_i] <= wr_mode_i;
            imm_q[wr_idx_i]  <= wr_imm_i;
        end
    end

    // Read before write: a same-cycle write shows up next cycle.
    assign rd_mode_o = mode_q[rd_idx_i];
    assign rd_imm_o  = imm_q[rd_idx_i];

endmodule

// File: rtl/dpu_sequencer.sv
// DPU run-time sequencer: program registers, dwell/iteration FSM.
// DPU_SEQUENCER_ACC_CLEAR_PER_ITER_EN: acc_clear on every iteration.
module dpu_sequencer
    import dpu_sequencer_pkg::*;
#(
    parameter int NUM_STATES  = DPU_NUM_STATES,
    parameter int DELAY_WIDTH = DPU_DELAY_W,
    parameter int MODE_WIDTH  = DPU_MODE_W,
    parameter int IMM_WIDTH   = DPU_IMM_W,
    parameter int ITER_WIDTH  = DPU_ITER_W,
    localparam int IW         = $clog2(NUM_STATES),
    localparam int PDW        = (NUM_STATES-1)*DELAY_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  slot_we,
    input  logic [IW-1:0]         slot_idx,
    input  logic [MODE_WIDTH-1:0] slot_mode,
    input  logic [IMM_WIDTH-1:0]  slot_imm,
    input  logic                  prog_we,
    input  logic [PDW-1:0]        prog_delays,
    input  logic [IW-1:0]         prog_last,
    input  logic [ITER_WIDTH-1:0] prog_iter,
    input  logic                  activate,
    output logic                  busy,
    output logic                  done,
    output logic [IW-1:0]         state,
    output logic [MODE_WIDTH-1:0] mode,
    output logic [IMM_WIDTH-1:0]  immediate,
    output logic                  acc_clear
);

`ifdef DPU_SEQUENCER_ACC_CLEAR_PER_ITER_EN
    localparam bit CLR_PER_ITER = 1'b1;
`else
    localparam bit CLR_PER_ITER = 1'b0;
`endif

    seq_state_e fsm_q, fsm_d;

    logic [IW-1:0]          idx_q,    idx_d;
    logic [DELAY_WIDTH-1:0] dwell_q,  dwell_d;
    logic [ITER_WIDTH-1:0]  iter_q,   iter_d;
    logic                   clr_q,    clr_d;
    logic                   done_q,   done_d;
    logic [PDW-1:0]         delays_q, delays_d;
    logic [IW-1:0]          last_q,   last_d;
    logic [ITER_WIDTH-1:0]  piter_q,  piter_d;

    logic [IW-1:0]          nxt_idx;
    logic [MODE_WIDTH-1:0]  rd_mode;
    logic [IMM_WIDTH-1:0]   rd_imm;

    // Out-of-range index (the slot past the last delay) reads as 0.
    function automatic logic [DELAY_WIDTH-1:0] delay_of(
        input logic [IW-1:0] s
    );
        delay_of = '0;
        for (int k = 0; k < NUM_STATES-1; k++) begin
            if (s == IW'(k)) delay_of = delays_q[k*DELAY_WIDTH +: DELAY_WIDTH];
        end
    endfunction

    assign nxt_idx = idx_q + IW'(1);

    always_comb begin
        fsm_d    = fsm_q;
        idx_d    = idx_q;
        dwell_d  = dwell_q;
        iter_d   = iter_q;
        clr_d    = 1'b0;
        done_d   = 1'b0;
        delays_d = delays_q;
        last_d   = last_q;
        piter_d  = piter_q;
        unique case (fsm_q)
            S_IDLE: begin
                idx_d = '0;
                if (prog_we) begin
                    delays_d = prog_delays;
                    last_d   = prog_last;
                    piter_d  = prog_iter;
                end else if (activate) begin
                    fsm_d   = S_RUN;
                    dwell_d = (last_q == '0) ? '0 : delay_of('0);
                    iter_d  = piter_q;
                    clr_d   = 1'b1;
                end
            end
            S_RUN: begin
                if (idx_q == last_q) begin
                    if (iter_q != '0) begin
                        iter_d  = iter_q - ITER_WIDTH'(1);
                        idx_d   = '0;
                        dwell_d = (last_q == '0) ? '0 : delay_of('0);
                        clr_d   = CLR_PER_ITER;
                    end else begin
                        fsm_d   = S_IDLE;
                        idx_d   = '0;
                        dwell_d = '0;
                        done_d  = 1'b1;
                    end
                end else if (dwell_q != '0) begin
                    dwell_d = dwell_q - DELAY_WIDTH'(1);
                end else begin
                    idx_d   = nxt_idx;
                    dwell_d = delay_of(nxt_idx);
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q    <= S_IDLE;
            idx_q    <= '0;
            dwell_q  <= '0;
            iter_q   <= '0;
            clr_q    <= 1'b0;
            done_q   <= 1'b0;
            delays_q <= '0;
            last_q   <= '0;
            piter_q  <= '0;
        end else begin
            fsm_q    <= fsm_d;
            idx_q    <= idx_d;
            dwell_q  <= dwell_d;
            iter_q   <= iter_d;
            clr_q    <= clr_d;
            done_q   <= done_d;
            delays_q <= delays_d;
            last_q   <= last_d;
            piter_q  <= piter_d;
        end
    end

    dpu_seq_slot_table #(
        .NUM_STATES (NUM_STATES),
        .MODE_WIDTH (MODE_WIDTH),
        .IMM_WIDTH  (IMM_WIDTH)
    ) u_slots (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (slot_we),
        .wr_idx_i  (slot_idx),
        .wr_mode_i (slot_mode),
        .wr_imm_i  (slot_imm),
        .rd_idx_i  (idx_q),
        .rd_mode_o (rd_mode),
        .rd_imm_o  (rd_imm)
    );

    assign busy      = (fsm_q == S_RUN);
    assign done      = done_q;
    assign state     = idx_q;
    assign acc_clear = clr_q;
    assign mode      = busy ? rd_mode : '0;
    assign immediate = busy ? rd_imm  : '0;

endmodule
